// File: rtl/regbank_pkg.sv
// Shared register-bank constants: special register numbers, stack-op codes
// and writeback requester indices, plus the stack-op legalisation helper.
package regbank_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;

    localparam logic [1:0] STACK_NOP = 2'b00;
    localparam logic [1:0] STACK_INC = 2'b01;
    localparam logic [1:0] STACK_DEC = 2'b10;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    // Only +4 / -4 reach the bank; anything else becomes a no-op.
    function automatic logic [1:0] stack_cmd(input logic [1:0] op);
        return ((op == STACK_INC) || (op == STACK_DEC)) ? op : STACK_NOP;
    endfunction

endpackage

// File: rtl/wb_grant_arb.sv
// One-hot grant generator for the writeback requesters.
// Fixed priority (index 0 highest) by default; `RR_ARB_EN selects
// round-robin with a pointer that moves past the last granted index.
module wb_grant_arb #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant
);

`ifdef RR_ARB_EN
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // Search from the pointer, wrapping, and pick the first active request.
    always_comb begin
        logic found;
        int   idx;
        o_grant   = '0;
        w_ptr_nxt = r_ptr;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                w_ptr_nxt    = PW'((idx + 1) % NUM_REQ);
            end
        end
    end

    // Pointer only moves when something was granted.
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= '0;
        else if (|i_req)
            r_ptr <= w_ptr_nxt;
    end
`else
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ reset;

    // Lowest active index wins.
    always_comb begin
        logic found;
        o_grant = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && i_req[k]) begin
                found      = 1'b1;
                o_grant[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-bank writeback arbiter: grants one writeback requester and the
// stack-op requester per cycle, registers the bank command, and keeps a
// pending-write scoreboard for decode.
// Optional: define RR_ARB_EN for round-robin instead of fixed priority.
module reg_wb_arbiter
    import regbank_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       stack_valid,
    input  logic [1:0]                 stack_op,
    output logic                       stack_ready,
    input  logic                       alloc_valid,
    input  logic [ADDR_W-1:0]          alloc_addr,
    output logic [31:0]                busy,
    output logic [ADDR_W-1:0]          regWrite,
    output logic [DATA_W-1:0]          regWriteData,
    output logic                       write,
    output logic [1:0]                 stackOp
);

    localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] A_SP   = ADDR_W'(REG_SP);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_any_grant;
    logic               w_issue;
    logic               w_sp_hit;
    logic [31:0]        w_busy_nxt;

    logic               r_write;
    logic [ADDR_W-1:0]  r_regWrite;
    logic [DATA_W-1:0]  r_regWriteData;
    logic [1:0]         r_stackOp;
    logic [31:0]        r_busy;

    // Requests seen during reset are never granted.
    assign w_req = reset ? '0 : req_valid;

    wb_grant_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    // Route the granted requester's address and data.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // r0 writes are consumed but never reach the bank; r29 writes hold off
    // the stack op one cycle so the bank never sees both on the SP.
    assign w_any_grant = |w_grant;
    assign w_issue     = w_any_grant && (w_sel_addr != A_ZERO);
    assign w_sp_hit    = w_issue && (w_sel_addr == A_SP);
    assign req_ready   = w_grant;
    assign stack_ready = !reset && stack_valid && !w_sp_hit;

    // Scoreboard update: issued write clears, alloc sets, set wins on a tie.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r < 32; r++) begin
            if (w_issue && (w_sel_addr == ADDR_W'(r)))
                w_busy_nxt[r] = 1'b0;
            if (alloc_valid && (alloc_addr == ADDR_W'(r)))
                w_busy_nxt[r] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Registered bank command and scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write        <= 1'b0;
            r_regWrite     <= '0;
            r_regWriteData <= '0;
            r_stackOp      <= STACK_NOP;
            r_busy         <= '0;
        end else begin
            r_write   <= w_issue;
            r_stackOp <= stack_ready ? stack_cmd(stack_op) : STACK_NOP;
            r_busy    <= w_busy_nxt;
            if (w_any_grant) begin
                r_regWrite     <= w_sel_addr;
                r_regWriteData <= w_sel_data;
            end
        end
    end

    assign write        = r_write;
    assign regWrite     = r_regWrite;
    assign regWriteData = r_regWriteData;
    assign stackOp      = r_stackOp;
    assign busy         = r_busy;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_reg_wb_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              stack_valid;
    logic [1:0]        stack_op;
    logic              stack_ready;
    logic              alloc_valid;
    logic [AW-1:0]     alloc_addr;
    logic [31:0]       busy;
    logic [AW-1:0]     regWrite;
    logic [DW-1:0]     regWriteData;
    logic              write;
    logic [1:0]        stackOp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .stack_valid(stack_valid), .stack_op(stack_op), .stack_ready(stack_ready),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .busy(busy), .regWrite(regWrite), .regWriteData(regWriteData),
        .write(write), .stackOp(stackOp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        stack_valid = 1'b0;
        stack_op    = 2'b00;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        req_valid   = 3'b111;
        req_addr    = {5'd6, 5'd4, 5'd3};
        req_data    = {32'hC, 32'hB, 32'hA};
        stack_valid = 1'b1;
        stack_op    = 2'b01;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        tick();
        tick();
        checks++;
        if ({write, stackOp, busy, req_ready, stack_ready} !== '0 || regWrite !== '0 || regWriteData !== '0) begin
            errors++;
            $display("FAIL reset_state: write=%b stackOp=%b busy=%h ready=%b sready=%b rw=%0d rwd=%h",
                     write, stackOp, busy, req_ready, stack_ready, regWrite, regWriteData);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if (write !== 1'b0 || busy !== 32'h0 || stackOp !== 2'b00) begin
            errors++;
            $display("FAIL reset_not_retained: write=%b busy=%h stackOp=%b exp 0", write, busy, stackOp);
        end
    endtask

    task automatic test_single_write;
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd5;
        req_data[0 +: DW] = 32'h1234;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL single_ready: got %b exp 001", req_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (write !== 1'b1 || regWrite !== 5'd5 || regWriteData !== 32'h1234) begin
            errors++;
            $display("FAIL single_cmd: write=%b addr=%0d data=%h exp 1/5/1234", write, regWrite, regWriteData);
        end
        tick();
        checks++;
        if (write !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: write=%b exp 0", write);
        end
    endtask

    task automatic test_contention;
        logic [NR-1:0] exp_g [4];
`ifdef RR_ARB_EN
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        do_reset();
        req_valid = 3'b111;
        req_addr  = {5'd6, 5'd4, 5'd3};
        req_data  = {32'h66, 32'h44, 32'h33};
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (req_ready !== exp_g[c]) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b exp %b", c, req_ready, exp_g[c]);
            end
            tick();
            checks++;
            if (write !== 1'b1) begin
                errors++;
                $display("FAIL contention_write[%0d]: write=%b exp 1", c, write);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_r29;
        do_reset();
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd29;
        req_data[0 +: DW] = 32'd100;
        stack_valid = 1'b1;
        stack_op    = 2'b01;
        #1;
        checks++;
        if (req_ready !== 3'b001 || stack_ready !== 1'b0) begin
            errors++;
            $display("FAIL r29_hold: ready=%b sready=%b exp 001/0", req_ready, stack_ready);
        end
        tick();
        req_valid = 3'b000;
        #1;
        checks++;
        if (write !== 1'b1 || regWrite !== 5'd29 || regWriteData !== 32'd100 || stackOp !== 2'b00 || stack_ready !== 1'b1) begin
            errors++;
            $display("FAIL r29_write: write=%b addr=%0d data=%0d stackOp=%b sready=%b",
                     write, regWrite, regWriteData, stackOp, stack_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (stackOp !== 2'b01 || write !== 1'b0) begin
            errors++;
            $display("FAIL r29_stack: stackOp=%b write=%b exp 01/0", stackOp, write);
        end
        tick();
    endtask

    task automatic test_scoreboard;
        do_reset();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (busy !== 32'h80) begin
            errors++;
            $display("FAIL sb_set: busy=%h exp 00000080", busy);
        end
        tick();
        req_valid = 3'b010;
        req_addr[AW +: AW] = 5'd7;
        req_data[DW +: DW] = 32'h77;
        tick();
        req_valid = 3'b000;
        checks++;
        if (write !== 1'b1 || regWrite !== 5'd7 || busy !== 32'h0) begin
            errors++;
            $display("FAIL sb_clear: write=%b addr=%0d busy=%h exp 1/7/0", write, regWrite, busy);
        end
        alloc_valid = 1'b1;
        tick();
        req_valid = 3'b010;
        tick();
        idle_inputs();
        checks++;
        if (write !== 1'b1 || busy !== 32'h80) begin
            errors++;
            $display("FAIL sb_set_wins: write=%b busy=%h exp 1/00000080", write, busy);
        end
        alloc_valid = 1'b1;
        alloc_addr  = 5'd0;
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (busy !== 32'h80) begin
            errors++;
            $display("FAIL sb_alloc0: busy=%h exp 00000080", busy);
        end
    endtask

    task automatic test_zero_noop;
        do_reset();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        tick();
        alloc_valid = 1'b0;
        req_valid   = 3'b100;
        req_addr[2*AW +: AW] = 5'd0;
        req_data[2*DW +: DW] = 32'hDEAD;
        stack_valid = 1'b1;
        stack_op    = 2'b11;
        #1;
        checks++;
        if (req_ready !== 3'b100 || stack_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: ready=%b sready=%b exp 100/1", req_ready, stack_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (write !== 1'b0 || stackOp !== 2'b00 || busy !== 32'h200) begin
            errors++;
            $display("FAIL zero_cmd: write=%b stackOp=%b busy=%h exp 0/00/00000200", write, stackOp, busy);
        end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd13;
        tick();
        alloc_valid = 1'b0;
        req_valid   = 3'b010;
        req_addr[AW +: AW] = 5'd12;
        req_data[DW +: DW] = 32'h12;
        stack_valid = 1'b1;
        stack_op    = 2'b10;
        tick();
        reset     = 1'b1;
        req_valid = 3'b111;
        #1;
        checks++;
        if (write !== 1'b1 || req_ready !== 3'b000 || stack_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_pre: write=%b ready=%b sready=%b exp 1/000/0", write, req_ready, stack_ready);
        end
        tick();
        checks++;
        if (write !== 1'b0 || busy !== 32'h0 || stackOp !== 2'b00) begin
            errors++;
            $display("FAIL midflight_flush: write=%b busy=%h stackOp=%b exp 0", write, busy, stackOp);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL midflight_ptr: ready=%b exp 001", req_ready);
        end
        idle_inputs();
        tick();
    endtask

    // Reference: the requester to grant given the active set and the search
    // start (always 0 for fixed priority).
    function automatic int model_grant(input logic [NR-1:0] v, input int start);
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    task automatic test_random;
        int          m_ptr;
        logic [31:0] m_busy;
        logic        m_write;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data;
        logic [1:0]  m_sop;
        int          g;
        logic [NR-1:0] eg;
        logic        esr;
        logic [AW-1:0] ga;
        do_reset();
        m_ptr = 0; m_busy = '0; m_write = 1'b0; m_addr = '0; m_data = '0; m_sop = 2'b00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom_range(2) == 0)) begin
                    req_valid[i] = 1'b1;
                    case ($urandom_range(5))
                        0:       req_addr[i*AW +: AW] = 5'd29;
                        1:       req_addr[i*AW +: AW] = 5'd0;
                        default: req_addr[i*AW +: AW] = AW'($urandom_range(31));
                    endcase
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            if (!stack_valid && ($urandom_range(1) == 0)) begin
                stack_valid = 1'b1;
                stack_op    = 2'($urandom_range(3));
            end
            alloc_valid = ($urandom_range(2) == 0);
            alloc_addr  = AW'($urandom_range(31));
            #1;
`ifdef RR_ARB_EN
            g = model_grant(req_valid, m_ptr);
`else
            g = model_grant(req_valid, 0);
`endif
            eg  = (g >= 0) ? NR'(1 << g) : '0;
            ga  = (g >= 0) ? req_addr[g*AW +: AW] : '0;
            esr = stack_valid && !((g >= 0) && (ga == 5'd29));
            checks++;
            if (req_ready !== eg || stack_ready !== esr) begin
                errors++;
                $display("FAIL rand_ready[%0d]: ready=%b sready=%b exp %b/%b", cyc, req_ready, stack_ready, eg, esr);
            end
            m_write = (g >= 0) && (ga != 0);
            if (g >= 0) begin
                m_addr = ga;
                m_data = req_data[g*DW +: DW];
                m_ptr  = (g + 1) % NR;
                if (ga != 0) m_busy[ga] = 1'b0;
            end
            if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
            m_sop = (esr && (stack_op == 2'b01 || stack_op == 2'b10)) ? stack_op : 2'b00;
            tick();
            checks++;
            if (write !== m_write || stackOp !== m_sop || busy !== m_busy ||
                (m_write && (regWrite !== m_addr || regWriteData !== m_data))) begin
                errors++;
                $display("FAIL rand_cmd[%0d]: w=%b a=%0d d=%h sop=%b busy=%h exp w=%b a=%0d d=%h sop=%b busy=%h",
                         cyc, write, regWrite, regWriteData, stackOp, busy, m_write, m_addr, m_data, m_sop, m_busy);
            end
            if (g >= 0) req_valid[g] = 1'b0;
            if (esr) stack_valid = 1'b0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_write();
        test_contention();
        test_r29();
        test_scoreboard();
        test_zero_noop();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
